// File: rtl/file_loader.sv
// file_loader: moves DATA_W-bit captured words into byte-wide RAM as
// consecutive bytes starting at a programmable base address.
// Optional build macro FILE_LOADER_CHECKSUM_EN adds a checksum[7:0] output
// holding the modulo-256 sum of all bytes taken by the RAM since the last
// accepted start.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; transfer parameters latched on start
// WAIT_WORD | in_ready high, waiting for the next captured word
// EMIT      | presenting one byte per cycle to RAM, holding on ram_wait
// DONE      | one-cycle completion pulse, then back to IDLE
module file_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] ram_base,
  input  logic [LEN_W-1:0]  word_count,
  input  logic              big_endian,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  input  logic              ram_wait,
  output logic              busy,
  output logic              done
`ifdef FILE_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_WORD = 2'd1;
  localparam logic [1:0] EMIT      = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addrReg;
  logic [LEN_W-1:0]  wordsLeft;
  logic              modeBe;
  logic [DATA_W-1:0] wordReg;
  logic [IDX_W-1:0]  byteIdx;
  logic [IDX_W-1:0]  byteSel;
  logic [DATA_W-1:0] wordShifted;
  logic [7:0]        curByte;
  logic              startAccept;
  logic              byteAccept;

  // Pick the byte lane for the current position according to the latched byte order
  always_comb begin
    byteSel     = modeBe ? (LAST_IDX - byteIdx) : byteIdx;
    wordShifted = wordReg >> {byteSel, 3'b000};
    curByte     = wordShifted[7:0];
  end

  assign startAccept = (state == IDLE) && start;
  assign byteAccept  = (state == EMIT) && !ram_wait;

  // Outputs decode from registered state only; nothing here depends on an input
  assign in_ready  = (state == WAIT_WORD);
  assign ram_write = (state == EMIT);
  assign ram_addr  = addrReg;
  assign ram_data  = curByte;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Sequencer: latch parameters on start, capture words, walk bytes out to RAM
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      addrReg   <= '0;
      wordsLeft <= '0;
      modeBe    <= 1'b0;
      wordReg   <= '0;
      byteIdx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addrReg   <= ram_base;
            wordsLeft <= word_count;
            modeBe    <= big_endian;
            state     <= (word_count == '0) ? DONE : WAIT_WORD;
          end
        end
        WAIT_WORD: begin
          if (in_valid) begin
            wordReg <= in_data;
            byteIdx <= '0;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (!ram_wait) begin
            addrReg <= addrReg + ADDR_W'(1);
            if (byteIdx == LAST_IDX) begin
              byteIdx   <= '0;
              // Saturating decrement; a zero count never reaches EMIT but stays safe
              wordsLeft <= (wordsLeft != '0) ? (wordsLeft - LEN_W'(1)) : '0;
              state     <= (wordsLeft <= LEN_W'(1)) ? DONE : WAIT_WORD;
            end else begin
              byteIdx <= byteIdx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FILE_LOADER_CHECKSUM_EN
  logic [7:0] sumReg;

  // Running byte sum of accepted RAM writes, restarted on every accepted start
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sumReg <= '0;
    end else if (startAccept) begin
      sumReg <= '0;
    end else if (byteAccept) begin
      sumReg <= sumReg + curByte;
    end
  end

  assign checksum = sumReg;
`endif

endmodule

// File: tb/tb_file_loader.sv
// tb_file_loader: randomized and directed transfers for file_loader checked
// against a byte-list reference model built from the word list, base address
// and byte order.
module tb_file_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;
  localparam int BYTES  = DATA_W / 8;

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] ram_base = '0;
  logic [LEN_W-1:0]  word_count = '0;
  logic              big_endian = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_wait = 1'b0;
  logic              busy;
  logic              done;
`ifdef FILE_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  file_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .ram_base   (ram_base),
    .word_count (word_count),
    .big_endian (big_endian),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_write  (ram_write),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wait   (ram_wait),
    .busy       (busy),
    .done       (done)
`ifdef FILE_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wrAddr[$];
  logic [7:0]        wrData[$];
  logic [DATA_W-1:0] wordsQ[$];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Record every byte the RAM takes (write strobe with no stall)
  always @(negedge clk) begin
    if (ram_write && !ram_wait) begin
      wrAddr.push_back(ram_addr);
      wrData.push_back(ram_data);
    end
  end

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
  task automatic runXfer(input logic [ADDR_W-1:0] base, input int n, input bit be,
                         input int stallPct, input int gapPct,
                         input int stallOnByte, input int stallLen, input int gapLen,
                         input bit exact, input string tag);
    logic [ADDR_W-1:0] expAddr[$];
    logic [7:0]        expData[$];
    logic [7:0]        sum;
    int idx, cyc, extra, bytesSeen, stallLeft, rdySeen, busyLow, doneCyc, expLat, k, nCmp;
    bit doneSeen;
`ifdef FILE_LOADER_CHECKSUM_EN
    logic [7:0] ck;
    ck = '0;
`endif
    while (wordsQ.size() < n) wordsQ.push_back(DATA_W'($urandom));
    sum = '0;
    k = 0;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        int sh;
        logic [7:0] byt;
        sh  = be ? 8 * (BYTES - 1 - b) : 8 * b;
        byt = 8'(wordsQ[w] >> sh);
        expAddr.push_back(base + ADDR_W'(k));
        expData.push_back(byt);
        sum = sum + byt;
        k++;
      end
    end
    wrAddr.delete();
    wrData.delete();

    ram_base = base; word_count = LEN_W'(n); big_endian = be;
    start = 1'b1; in_valid = 1'b0; ram_wait = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    ram_base = ADDR_W'($urandom); word_count = LEN_W'($urandom); big_endian = ~be;

    idx = 0; cyc = 0; extra = 0; bytesSeen = 0; stallLeft = stallLen;
    rdySeen = 0; busyLow = 0; doneSeen = 1'b0; doneCyc = 0;
    while (!doneSeen && cyc < 500) begin
      in_valid = (idx < n) && (cyc >= gapLen) && ($urandom_range(99) >= gapPct);
      in_data  = (idx < n) ? wordsQ[idx] : DATA_W'($urandom);
      ram_wait = (bytesSeen == stallOnByte && stallLeft > 0) || ($urandom_range(99) < stallPct);
      @(negedge clk);
      cyc++;
      if (done) begin
        doneSeen = 1'b1;
        doneCyc  = cyc;
        checkVal({tag, ".busyAtDone"}, 64'(busy), 64'(1));
`ifdef FILE_LOADER_CHECKSUM_EN
        ck = checksum;
`endif
      end else begin
        if (!busy) busyLow++;
        if (gapLen > 0 && cyc <= gapLen) begin
          checkVal({tag, ".gapReady"}, 64'(in_ready), 64'(1));
          checkVal({tag, ".gapNoWrite"}, 64'(ram_write), 64'(0));
        end
        if (in_ready) begin
          rdySeen++;
          if (in_valid) idx++;
          else extra++;
        end
        if (ram_write) begin
          if (ram_wait) begin
            extra++;
            if (stallLeft > 0 && bytesSeen == stallOnByte && bytesSeen < expAddr.size()) begin
              stallLeft--;
              checkVal({tag, ".stallAddr"}, 64'(ram_addr), 64'(expAddr[bytesSeen]));
              checkVal({tag, ".stallData"}, 64'(ram_data), 64'(expData[bytesSeen]));
            end
          end else begin
            bytesSeen++;
          end
        end
        @(posedge clk); #1;
      end
    end

    checkVal({tag, ".doneSeen"}, 64'(doneSeen), 64'(1));
    expLat = 1 + n * (BYTES + 1) + (exact ? (stallLen + gapLen) : extra);
    checkVal({tag, ".latency"}, 64'(doneCyc), 64'(expLat));
    checkVal({tag, ".busyLow"}, 64'(busyLow), 64'(0));
    checkVal({tag, ".nWrites"}, 64'(wrAddr.size()), 64'(expAddr.size()));
    nCmp = (wrAddr.size() < expAddr.size()) ? wrAddr.size() : expAddr.size();
    for (int i = 0; i < nCmp; i++) begin
      checkVal({tag, ".addr"}, 64'(wrAddr[i]), 64'(expAddr[i]));
      checkVal({tag, ".data"}, 64'(wrData[i]), 64'(expData[i]));
    end
    if (n == 0) checkVal({tag, ".noReady"}, 64'(rdySeen), 64'(0));
`ifdef FILE_LOADER_CHECKSUM_EN
    checkVal({tag, ".checksum"}, 64'(ck), 64'(sum));
`endif
    @(posedge clk); #1;
    checkVal({tag, ".donePulse"}, 64'(done), 64'(0));
    checkVal({tag, ".busyAfter"}, 64'(busy), 64'(0));
    in_valid = 1'b0;
    ram_wait = 1'b0;
    wordsQ.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    RST = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst.in_ready", 64'(in_ready), 64'(0));
    checkVal("rst.ram_write", 64'(ram_write), 64'(0));
    checkVal("rst.ram_addr", 64'(ram_addr), 64'(0));
    checkVal("rst.ram_data", 64'(ram_data), 64'(0));
    checkVal("rst.busy", 64'(busy), 64'(0));
    checkVal("rst.done", 64'(done), 64'(0));
`ifdef FILE_LOADER_CHECKSUM_EN
    checkVal("rst.checksum", 64'(checksum), 64'(0));
`endif
    @(posedge clk); #1;
    RST = 1'b0;

    // Directed transfers
    wordsQ = '{16'hABCD};
    runXfer(16'h0100, 1, 1'b1, 0, 0, -1, 0, 0, 1'b1, "be1");
    wordsQ = '{16'hABCD};
    runXfer(16'h0100, 1, 1'b0, 0, 0, -1, 0, 0, 1'b1, "be0");
    wordsQ = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    runXfer(16'hFFFE, 4, 1'b1, 0, 0, -1, 0, 0, 1'b1, "wrap");
    runXfer(16'h0040, 0, 1'b1, 0, 0, -1, 0, 0, 1'b1, "zero");
    runXfer(16'h0400, 2, 1'b0, 0, 0, 1, 3, 5, 1'b1, "stallgap");

    // Reset in the middle of a two-word transfer
    wrAddr.delete();
    wrData.delete();
    ram_base = 16'h0300; word_count = 16'd2; big_endian = 1'b1;
    start = 1'b1; in_valid = 1'b0; ram_wait = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(ram_write && !ram_wait) && cyc < 50);
    checkVal("rstmid.firstByte", 64'(ram_write), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    RST = 1'b1;
    #1;
    checkVal("rstmid.in_ready", 64'(in_ready), 64'(0));
    checkVal("rstmid.ram_write", 64'(ram_write), 64'(0));
    checkVal("rstmid.ram_addr", 64'(ram_addr), 64'(0));
    checkVal("rstmid.ram_data", 64'(ram_data), 64'(0));
    checkVal("rstmid.busy", 64'(busy), 64'(0));
    checkVal("rstmid.done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    checkVal("rstmid.heldWrite", 64'(ram_write), 64'(0));
    @(posedge clk); #1;
    RST = 1'b0;
    checkVal("rstmid.nWrites", 64'(wrAddr.size()), 64'(1));
    wordsQ = '{16'h1234};
    runXfer(16'h0200, 1, 1'b1, 0, 0, -1, 0, 0, 1'b1, "afterRst");

    // Randomized transfers with random stalls and input gaps
    for (int t = 0; t < 12; t++) begin
      runXfer(ADDR_W'($urandom), int'($urandom_range(1, 5)), 1'($urandom_range(1)),
              30, 30, -1, 0, 0, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
